// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: shared opcode/state types and opcode classification helpers
package acc_cpu_pkg;
  localparam int OPC_W = 4;
  typedef enum logic [OPC_W-1:0] {
    OP_ADD    = 4'h0,
    OP_AND    = 4'h1,
    OP_XOR    = 4'h2,
    OP_OR     = 4'h3,
    OP_SL     = 4'h4,
    OP_SR     = 4'h5,
    OP_LOAD   = 4'h6,
    OP_IMM    = 4'h7,
    OP_JZ     = 4'h8,
    OP_STORE  = 4'h9,
    OP_SETOFF = 4'hA,
    OP_PUSH   = 4'hB,
    OP_POP    = 4'hC,
    OP_JMP    = 4'hD,
    OP_NOP    = 4'hE,
    OP_HALT   = 4'hF
  } opcode_e;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;
  function automatic logic is_mem_op(opcode_e op);
    return op inside {OP_ADD, OP_AND, OP_XOR, OP_OR, OP_LOAD, OP_STORE, OP_PUSH, OP_POP};
  endfunction
  function automatic logic is_write_op(opcode_e op);
    return op inside {OP_STORE, OP_PUSH};
  endfunction
endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational accumulator update for arithmetic, logic, shift and load ops
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] operand,
  input  opcode_e      opcode,
  output logic [N-1:0] result
);
  localparam int SW = $clog2(N);
  logic [SW-1:0] sh;
  assign sh = operand[SW-1:0];
  // new accumulator value; ops that do not touch acc pass it through
  always_comb begin
    result = acc;
    case (opcode)
      OP_ADD:                 result = acc + operand;
      OP_AND:                 result = acc & operand;
      OP_XOR:                 result = acc ^ operand;
      OP_OR:                  result = acc | operand;
      OP_SL:                  result = acc << sh;
      OP_SR:                  result = acc >> sh;
      OP_LOAD, OP_IMM, OP_POP: result = operand;
      default:                result = acc;
    endcase
  end
endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU with req/ready instruction and data memories
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int          N       = 16,
  parameter int unsigned SP_INIT = 'hFFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [N-1:0] imem_rdata,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_ready,
  input  logic [N-1:0] dmem_rdata,
  output logic [N-1:0] acc_o,
  output logic [N-1:0] pc_o,
  output logic         halted
);
  localparam logic [N-1:0] SP_RST = N'(SP_INIT);
  state_e state_q, state_d;
  logic [N-1:0] acc_q, acc_d, off_q, off_d, sp_q, sp_d, pc_q, pc_d, instr_q, instr_d;
  logic [N-1:0] opnd, ea, alu_opnd, alu_res;
  opcode_e op;
  logic jump;
  assign op       = opcode_e'(instr_q[N-1:N-OPC_W]);
  assign opnd     = {{OPC_W{1'b0}}, instr_q[N-OPC_W-1:0]};
  assign ea       = opnd + off_q;
  assign alu_opnd = state_q == S_MEM ? dmem_rdata : opnd;
  assign jump     = op == OP_JMP || (op == OP_JZ && acc_q == '0);
  acc_cpu_alu #(.N(N)) u_alu (
    .acc    (acc_q),
    .operand(alu_opnd),
    .opcode (op),
    .result (alu_res)
  );
  // fetch request is gated by rst_n so it falls the moment reset is asserted
  assign imem_req   = rst_n && state_q == S_FETCH;
  assign imem_addr  = pc_q;
  assign dmem_req   = state_q == S_MEM;
  assign dmem_we    = dmem_req && is_write_op(op);
  assign dmem_addr  = op == OP_PUSH ? sp_q - N'(1) : op == OP_POP ? sp_q : ea;
  assign dmem_wdata = acc_q;
  assign acc_o      = acc_q;
  assign pc_o       = pc_q;
  assign halted     = state_q == S_HALT;
  // next-state: fetch latches instr and bumps pc, exec retires register ops, mem commits on ready
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    off_d   = off_q;
    sp_d    = sp_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_FETCH: if (imem_ready) begin
        instr_d = imem_rdata;
        pc_d    = pc_q + N'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = is_mem_op(op) ? S_MEM : op == OP_HALT ? S_HALT : S_FETCH;
        acc_d   = op inside {OP_SL, OP_SR, OP_IMM} ? alu_res : acc_q;
        off_d   = op == OP_SETOFF ? acc_q : off_q;
        pc_d    = jump ? opnd : pc_q;
      end
      S_MEM: if (dmem_ready) begin
        state_d = S_FETCH;
        acc_d   = is_write_op(op) ? acc_q : alu_res;
        sp_d    = op == OP_PUSH ? sp_q - N'(1) : op == OP_POP ? sp_q + N'(1) : sp_q;
      end
      default: ;
    endcase
  end
  // architectural state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      acc_q   <= '0;
      off_q   <= '0;
      sp_q    <= SP_RST;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      off_q   <= off_d;
      sp_q    <= sp_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: randomized programs checked against an instruction-level reference model
module tb_acc_cpu_core;
  localparam int N = 16;
  localparam logic [15:0] SP0 = 16'h0000;
  logic clk = 0, rst_n = 0;
  logic imem_req, imem_ready = 0, dmem_req, dmem_we, dmem_ready = 0, halted;
  logic [15:0] imem_addr, imem_rdata = 0, dmem_addr, dmem_wdata, dmem_rdata = 0, acc_o, pc_o;
  logic [15:0] imem [65536];
  logic [15:0] dmem [65536];
  logic [15:0] md [65536];
  int checks = 0, errors = 0;
  int iw_max = 0, dw_max = 0, dw_fix = -1, icnt = -1, dcnt = -1;
  int dlen = 0, nacc = 0, nwr = 0;
  int dlens[$];
  logic [32:0] dsave;
  logic [15:0] last_raddr = 0, pacc = 0;

  always #5 clk = ~clk;

  acc_cpu_core #(.N(N), .SP_INIT(32'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .acc_o(acc_o), .pc_o(pc_o), .halted(halted)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // instruction memory responder with random wait states
  always @(negedge clk) begin
    if (!imem_req) begin
      imem_ready = 0;
      icnt = -1;
    end else begin
      if (icnt < 0) icnt = int'($urandom_range(iw_max));
      if (icnt == 0) begin
        imem_ready = 1;
        imem_rdata = imem[imem_addr];
      end else begin
        imem_ready = 0;
        icnt--;
      end
    end
  end

  // data memory responder plus request-hold and activity monitors
  always @(negedge clk) begin
    if (!rst_n) begin
      nacc = 0; nwr = 0; dlen = 0; dlens.delete();
    end else if (pacc !== acc_o) nacc++;
    pacc = acc_o;
    if (!dmem_req) begin
      dmem_ready = 0;
      dcnt = -1;
      if (dlen > 0) dlens.push_back(dlen);
      dlen = 0;
    end else begin
      if (dlen == 0) dsave = {dmem_we, dmem_addr, dmem_wdata};
      else chk("dmem_hold", {dmem_we, dmem_addr, dmem_wdata}, dsave);
      dlen++;
      if (!dmem_we) last_raddr = dmem_addr;
      if (dcnt < 0) dcnt = dw_fix >= 0 ? dw_fix : int'($urandom_range(dw_max));
      if (dcnt == 0) begin
        dmem_ready = 1;
        if (dmem_we) begin
          dmem[dmem_addr] = dmem_wdata;
          nwr++;
        end else dmem_rdata = dmem[dmem_addr];
      end else begin
        dmem_ready = 0;
        dcnt--;
      end
    end
  end

  task automatic clear_imem();
    for (int a = 0; a < 64; a++) imem[a] = 16'hF000;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1 chk("reset_state", {acc_o, pc_o, halted, imem_req, dmem_req, dmem_we}, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    #1 chk("restart_fetch", {imem_req, imem_addr}, {1'b1, 16'h0000});
  endtask

  task automatic run(input int probe, output int cyc, output logic [15:0] ppc);
    do_reset();
    cyc = 0;
    ppc = 0;
    while (!halted && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1;
      if (cyc == probe) ppc = pc_o;
    end
    chk("halt_reached", halted, 1);
  endtask

  // instruction-set level model: executes the program directly on a copy of data memory
  task automatic model(output logic [15:0] macc, output logic [15:0] mpc, output int mcyc,
                       output int mwr, output bit mh);
    logic [15:0] acc, off, sp, pc, ins, opnd, ea;
    acc = 0; off = 0; sp = SP0; pc = 0; mh = 0; mcyc = 0; mwr = 0;
    for (int s = 0; s < 500 && !mh; s++) begin
      ins = imem[pc];
      pc = pc + 1;
      opnd = {4'h0, ins[11:0]};
      ea = opnd + off;
      mcyc += 2;
      case (ins[15:12])
        4'h0: begin acc = acc + md[ea]; mcyc++; end
        4'h1: begin acc = acc & md[ea]; mcyc++; end
        4'h2: begin acc = acc ^ md[ea]; mcyc++; end
        4'h3: begin acc = acc | md[ea]; mcyc++; end
        4'h4: acc = acc << opnd[3:0];
        4'h5: acc = acc >> opnd[3:0];
        4'h6: begin acc = md[ea]; mcyc++; end
        4'h7: acc = opnd;
        4'h8: if (acc == 0) pc = opnd;
        4'h9: begin md[ea] = acc; mwr++; mcyc++; end
        4'hA: off = acc;
        4'hB: begin sp = sp - 1; md[sp] = acc; mwr++; mcyc++; end
        4'hC: begin acc = md[sp]; sp = sp + 1; mcyc++; end
        4'hD: pc = opnd;
        4'hE: ;
        default: mh = 1;
      endcase
    end
    macc = acc;
    mpc = pc;
  endtask

  task automatic test_prog(input string name, input int probe, output logic [15:0] ppc);
    logic [15:0] macc, mpc;
    int mcyc, mwr, cyc, diffs;
    bit mh;
    for (int a = 0; a < 65536; a++) md[a] = dmem[a];
    model(macc, mpc, mcyc, mwr, mh);
    run(probe, cyc, ppc);
    chk({name, "_acc"}, acc_o, macc);
    chk({name, "_pc"}, pc_o, mpc);
    chk({name, "_halted"}, halted, mh);
    chk({name, "_writes"}, nwr, mwr);
    if (iw_max == 0 && dw_max == 0 && dw_fix <= 0) chk({name, "_cycles"}, cyc, mcyc);
    diffs = 0;
    for (int a = 0; a < 65536; a++) if (dmem[a] !== md[a]) diffs++;
    chk({name, "_mem"}, diffs, 0);
  endtask

  initial begin
    logic [15:0] ppc;
    int len;
    logic [3:0] op;
    bit seen;
    for (int a = 0; a < 65536; a++) dmem[a] = 16'($urandom);
    for (int a = 0; a < 65536; a++) imem[a] = 16'hF000;

    clear_imem();
    imem[0] = 16'h7005; imem[1] = 16'h000A; imem[2] = 16'h900B; imem[3] = 16'hF000;
    dmem[10] = 16'd7; dmem[11] = 16'd0;
    test_prog("add_store", 0, ppc);
    chk("add_store_m11", dmem[11], 16'd12);
    chk("add_store_state", {acc_o, pc_o, halted}, {16'd12, 16'd4, 1'b1});

    clear_imem();
    imem[0] = 16'h7003; imem[1] = 16'hA000; imem[2] = 16'h6004; imem[3] = 16'hF000;
    dmem[7] = 16'h00A5;
    test_prog("offset_load", 0, ppc);
    chk("offset_load_acc", acc_o, 16'h00A5);
    chk("offset_load_addr", last_raddr, 16'd7);

    clear_imem();
    imem[0] = 16'h7000; imem[1] = 16'h8006;
    imem[6] = 16'h7001; imem[7] = 16'h8000; imem[8] = 16'hF000;
    test_prog("jz", 4, ppc);
    chk("jz_taken_pc", ppc, 16'd6);
    chk("jz_fallthrough", {acc_o, pc_o}, {16'd1, 16'd9});

    clear_imem();
    imem[0] = 16'h7009; imem[1] = 16'hB000; imem[2] = 16'h7000; imem[3] = 16'hC000;
    imem[4] = 16'h9014; imem[5] = 16'h7004; imem[6] = 16'hB000; imem[7] = 16'hF000;
    test_prog("stack", 0, ppc);
    chk("stack_pop_m20", dmem[20], 16'd9);
    chk("stack_wrap_mffff", dmem[16'hFFFF], 16'd4);

    clear_imem();
    imem[0] = 16'h7005; imem[1] = 16'h000A; imem[2] = 16'h900B; imem[3] = 16'hF000;
    dmem[10] = 16'd7; dmem[11] = 16'd0;
    dw_fix = 3;
    test_prog("slow_add", 0, ppc);
    chk("slow_add_req_len", dlens.size() > 0 ? dlens[0] : 0, 4);
    chk("slow_add_acc_updates", nacc, 2);
    chk("slow_add_m11", dmem[11], 16'd12);

    dmem[11] = 16'h1234;
    dw_fix = 6;
    do_reset();
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = dmem_req && dmem_we;
    end
    chk("abort_store_seen", seen, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("abort_req_drop", {dmem_req, imem_req}, 0);
    chk("abort_regs", {acc_o, pc_o, halted}, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_write", dmem[11], 16'h1234);
    dw_fix = -1;
    test_prog("restart", 0, ppc);
    chk("restart_m11", dmem[11], 16'd12);

    for (int t = 0; t < 40; t++) begin
      iw_max = t % 2 ? int'($urandom_range(2)) : 0;
      dw_max = t % 2 ? int'($urandom_range(3)) : 0;
      len = int'($urandom_range(30, 8));
      clear_imem();
      for (int i = 0; i < len; i++) begin
        op = 4'($urandom_range(15));
        if (op == 4'hF && $urandom_range(3) != 0) op = 4'hE;
        imem[i] = (op == 4'h8 || op == 4'hD) ? {op, 12'($urandom_range(len, i + 1))}
                                             : {op, 12'($urandom)};
      end
      test_prog("rand", 0, ppc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
